// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline stage registers: skid state encoding
// and the default payload width.
package cpu_pipe_pkg;

  localparam int PIPE_DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic stage register (main + skid) with flush.
// Optional stall counter enabled by PIPE_SKID_PERF_EN.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_SKID_PERF_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, send;

  // Both handshake outputs decode straight from the state flops, so there is
  // no combinational path from out_ready to in_ready.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign accept = in_valid && in_ready;
  assign send   = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (accept && !send) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (accept && send) begin
          main_d  = in_data;
        end else if (send) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (send) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Payload regs may still load on a flush; they are don't-care once empty.
    if (flush) state_d = EMPTY;
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
